// File: rtl/morse_pkg.sv
// Shared definitions for the morse protocol checker.
// Contents: check-bit indices, check count, FSM state encoding.
package morse_pkg;

    localparam int N_CHK     = 5;
    localparam int CHK_MULTI = 0;   // more than one detector input high
    localparam int CHK_CGAP  = 1;   // illegal input inside a character gap
    localparam int CHK_WGAP  = 2;   // illegal input inside a word gap
    localparam int CHK_WORD  = 3;   // wrong sout code after a word space
    localparam int CHK_IDLE  = 4;   // wrong sout code right after reset

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGAP = 2'd1,
        ST_WGAP = 2'd2
    } morse_chk_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/morse_protocol_checker_if.sv
// Bundle of the monitored detector stream, checker controls and checker results.
//   master: drives the detector stream and controls, observes the results
//   slave : the checker itself
// Signals: chk_en, clr_err, dot_inp, dash_inp, char_space_inp, word_space_inp,
//          sout[OUT_W], err_pulse[N_CHK], err_sticky[N_CHK], err_cnt[CNT_W], busy
interface morse_protocol_checker_if #(
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
);
    import morse_pkg::*;

    logic             chk_en;
    logic             clr_err;
    logic             dot_inp;
    logic             dash_inp;
    logic             char_space_inp;
    logic             word_space_inp;
    logic [OUT_W-1:0] sout;
    logic [N_CHK-1:0] err_pulse;
    logic [N_CHK-1:0] err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;

    modport master (
        output chk_en, clr_err, dot_inp, dash_inp, char_space_inp, word_space_inp, sout,
        input  err_pulse, err_sticky, err_cnt, busy
    );

    modport slave (
        input  chk_en, clr_err, dot_inp, dash_inp, char_space_inp, word_space_inp, sout,
        output err_pulse, err_sticky, err_cnt, busy
    );

endinterface

// File: rtl/morse_err_accum.sv
// Error accumulator: registers the per-check error vector as one-cycle pulses,
// keeps a sticky OR of them and a saturating count of error cycles.
// Ports:
//   clk, rst      clock, async active-high reset
//   clr_err       sync clear of sticky flags and count
//   err_det       per-check errors detected this cycle (already gated by enable)
//   err_pulse     registered copy of err_det
//   err_sticky    sticky OR of pulses since reset/clear
//   err_cnt       cycles with any pulse bit, holds at all-ones
module morse_err_accum #(
    parameter int N_CHK = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_err,
    input  logic [N_CHK-1:0] err_det,
    output logic [N_CHK-1:0] err_pulse,
    output logic [N_CHK-1:0] err_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    logic any_err;

    assign any_err = |err_det;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse  <= '0;
            err_sticky <= '0;
            err_cnt    <= '0;
        end else begin
            err_pulse <= err_det;
            // A clear in the same cycle as a new error keeps that error.
            if (clr_err) begin
                err_sticky <= err_det;
                err_cnt    <= any_err ? CNT_W'(1) : '0;
            end else begin
                err_sticky <= err_sticky | err_det;
                if (any_err && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/morse_protocol_checker.sv
// Protocol monitor for the morse detector input/output stream.
// Checks single-symbol inputs, character/word gap timing, the word-space
// output code and the post-reset idle code. Results go through morse_err_accum.
// Ports:
//   clk, rst   clock, async active-high reset
//   bus        slave side of morse_protocol_checker_if (stream in, results out)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no gap window open; any single input is legal
// ST_CGAP | gap_cnt cycles left after char_space; dot/dash/word_space illegal
// ST_WGAP | gap_cnt cycles left after word_space; dot/dash/char_space illegal
module morse_protocol_checker
    import morse_pkg::*;
#(
    parameter int             CHAR_GAP  = 3,
    parameter int             WORD_GAP  = 7,
    parameter int             OUT_W     = 8,
    parameter logic [OUT_W-1:0] WORD_CODE = 8'h20,
    parameter logic [OUT_W-1:0] IDLE_CODE = 8'hFF,
    parameter int             CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    morse_protocol_checker_if.slave  bus
);

    localparam int GAP_W = $clog2(max_int(CHAR_GAP, WORD_GAP) + 1);
    localparam int WC_W  = $clog2(WORD_GAP + 2);

    morse_chk_state_t state, state_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic [WC_W-1:0]  wcnt, wcnt_nxt;
    logic             first_cyc;
    logic [3:0]       in_vec;
    logic             multi_in;
    logic             trig;
    logic             is_dd;
    logic             is_cs;
    logic             is_ws;
    logic [N_CHK-1:0] err_raw;
    logic [N_CHK-1:0] err_det;

    assign in_vec = {bus.word_space_inp, bus.char_space_inp, bus.dash_inp, bus.dot_inp};

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_in = |(in_vec & (in_vec - 4'd1));
    assign trig     = (in_vec != 4'd0) && !multi_in;
    assign is_dd    = trig && (bus.dot_inp || bus.dash_inp);
    assign is_cs    = trig && bus.char_space_inp;
    assign is_ws    = trig && bus.word_space_inp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            wcnt      <= '0;
            first_cyc <= 1'b1;
        end else begin
            state     <= state_nxt;
            gap_cnt   <= gap_nxt;
            wcnt      <= wcnt_nxt;
            first_cyc <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        wcnt_nxt  = wcnt;
        err_raw   = '0;

        err_raw[CHK_MULTI] = multi_in;
        err_raw[CHK_IDLE]  = first_cyc && (bus.sout != IDLE_CODE);

        // Word-out timer runs independently of the gap FSM; a reload or
        // cancel below overrides the countdown.
        if (wcnt == WC_W'(1)) begin
            err_raw[CHK_WORD] = (bus.sout != WORD_CODE);
            wcnt_nxt          = '0;
        end else if (wcnt != '0) begin
            wcnt_nxt = wcnt - WC_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (is_cs) begin
                    state_nxt = ST_CGAP;
                    gap_nxt   = GAP_W'(CHAR_GAP);
                end else if (is_ws) begin
                    state_nxt = ST_WGAP;
                    gap_nxt   = GAP_W'(WORD_GAP);
                    wcnt_nxt  = WC_W'(WORD_GAP + 1);
                end
            end
            ST_CGAP: begin
                if (is_dd) begin
                    err_raw[CHK_CGAP] = 1'b1;
                    state_nxt         = ST_IDLE;
                    gap_nxt           = '0;
                end else if (is_ws) begin
                    err_raw[CHK_CGAP] = 1'b1;
                    state_nxt         = ST_WGAP;
                    gap_nxt           = GAP_W'(WORD_GAP);
                    wcnt_nxt          = WC_W'(WORD_GAP + 1);
                end else if (is_cs) begin
                    gap_nxt = GAP_W'(CHAR_GAP);
                end else if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = ST_IDLE;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            ST_WGAP: begin
                if (is_dd) begin
                    err_raw[CHK_WGAP] = 1'b1;
                    wcnt_nxt          = '0;
                    state_nxt         = ST_IDLE;
                    gap_nxt           = '0;
                end else if (is_cs) begin
                    err_raw[CHK_WGAP] = 1'b1;
                    wcnt_nxt          = '0;
                    state_nxt         = ST_CGAP;
                    gap_nxt           = GAP_W'(CHAR_GAP);
                end else if (is_ws) begin
                    gap_nxt  = GAP_W'(WORD_GAP);
                    wcnt_nxt = WC_W'(WORD_GAP + 1);
                end else if (gap_cnt == GAP_W'(1)) begin
                    state_nxt = ST_IDLE;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gap_nxt   = '0;
            end
        endcase
    end

    // Tracking above always advances; only the reporting is gated.
    assign err_det = bus.chk_en ? err_raw : '0;

    assign bus.busy = (state != ST_IDLE) || (wcnt != '0);

    morse_err_accum #(
        .N_CHK (N_CHK),
        .CNT_W (CNT_W)
    ) u_err_accum (
        .clk        (clk),
        .rst        (rst),
        .clr_err    (bus.clr_err),
        .err_det    (err_det),
        .err_pulse  (bus.err_pulse),
        .err_sticky (bus.err_sticky),
        .err_cnt    (bus.err_cnt)
    );

endmodule

// File: tb/tb_morse_protocol_checker.sv
// Directed self-checking bench for morse_protocol_checker (default parameters:
// CHAR_GAP=3, WORD_GAP=7, WORD_CODE=8'h20, IDLE_CODE=8'hFF, CNT_W=8).
module tb_morse_protocol_checker;

    localparam logic [3:0] IN_NONE = 4'b0000;
    localparam logic [3:0] IN_DOT  = 4'b0001;
    localparam logic [3:0] IN_DASH = 4'b0010;
    localparam logic [3:0] IN_CS   = 4'b0100;
    localparam logic [3:0] IN_WS   = 4'b1000;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    morse_protocol_checker_if #(.OUT_W(8), .CNT_W(8)) bus ();

    morse_protocol_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, expected finish before 1000000");
        $fatal(1, "timeout");
    end

    // Apply one cycle of inputs {word_space, char_space, dash, dot}; returns
    // 1 time unit after the sampling edge with the inputs released.
    task automatic cyc(input logic [3:0] v);
        bus.dot_inp        = v[0];
        bus.dash_inp       = v[1];
        bus.char_space_inp = v[2];
        bus.word_space_inp = v[3];
        @(posedge clk);
        #1;
        bus.dot_inp        = 1'b0;
        bus.dash_inp       = 1'b0;
        bus.char_space_inp = 1'b0;
        bus.word_space_inp = 1'b0;
    endtask

    // Reset with the given sout value; the next cyc() is the first edge after release.
    task automatic do_reset(input logic [7:0] s);
        bus.sout = s;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sout = 8'hFF;
        @(posedge clk);
        #1;
        checks++;
        if (bus.err_pulse !== 5'b00000) begin
            failures++;
            $display("FAIL reset_pulse: got %b expected %b", bus.err_pulse, 5'b00000);
        end
        checks++;
        if ({bus.err_sticky, bus.err_cnt, bus.busy} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs: got sticky=%b cnt=%0d busy=%b expected all 0",
                     bus.err_sticky, bus.err_cnt, bus.busy);
        end
        rst = 1'b0;
        cyc(IN_NONE);
        checks++;
        if (bus.err_pulse !== 5'b00000) begin
            failures++;
            $display("FAIL idle_ok: got %b expected %b", bus.err_pulse, 5'b00000);
        end
        do_reset(8'h00);
        cyc(IN_NONE);
        checks++;
        if (bus.err_pulse !== 5'b10000) begin
            failures++;
            $display("FAIL idle_bad_pulse: got %b expected %b", bus.err_pulse, 5'b10000);
        end
        checks++;
        if (bus.err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL idle_bad_cnt: got %0d expected %0d", bus.err_cnt, 1);
        end
        cyc(IN_NONE);
        checks++;
        if ({bus.err_pulse, bus.err_cnt} !== {5'b00000, 8'd1}) begin
            failures++;
            $display("FAIL idle_once: got pulse=%b cnt=%0d expected pulse=00000 cnt=1",
                     bus.err_pulse, bus.err_cnt);
        end
        bus.sout = 8'hFF;
    endtask

    task automatic test_char_gap();
        do_reset(8'hFF);
        cyc(IN_NONE);
        cyc(IN_CS);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL cgap_busy: got %b expected %b", bus.busy, 1'b1);
        end
        cyc(IN_NONE);
        cyc(IN_DASH);
        checks++;
        if (bus.err_pulse !== 5'b00010) begin
            failures++;
            $display("FAIL cgap_dash_t2: got %b expected %b", bus.err_pulse, 5'b00010);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL cgap_dash_idle: got busy=%b expected %b", bus.busy, 1'b0);
        end
        cyc(IN_CS);
        cyc(IN_NONE);
        cyc(IN_NONE);
        cyc(IN_DOT);
        checks++;
        if (bus.err_pulse !== 5'b00010) begin
            failures++;
            $display("FAIL cgap_dot_last: got %b expected %b", bus.err_pulse, 5'b00010);
        end
        cyc(IN_CS);
        repeat (3) cyc(IN_NONE);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL cgap_window_end: got busy=%b expected %b", bus.busy, 1'b0);
        end
        cyc(IN_DASH);
        checks++;
        if (bus.err_pulse !== 5'b00000) begin
            failures++;
            $display("FAIL cgap_dash_t4: got %b expected %b", bus.err_pulse, 5'b00000);
        end
        checks++;
        if ({bus.err_sticky, bus.err_cnt} !== {5'b00010, 8'd2}) begin
            failures++;
            $display("FAIL cgap_sticky: got sticky=%b cnt=%0d expected sticky=00010 cnt=2",
                     bus.err_sticky, bus.err_cnt);
        end
    endtask

    task automatic test_word_out();
        do_reset(8'hFF);
        cyc(IN_NONE);
        bus.sout = 8'h20;
        cyc(IN_WS);
        repeat (7) cyc(IN_NONE);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL wout_pending_busy: got %b expected %b", bus.busy, 1'b1);
        end
        cyc(IN_NONE);
        checks++;
        if ({bus.err_pulse, bus.busy} !== {5'b00000, 1'b0}) begin
            failures++;
            $display("FAIL wout_good: got pulse=%b busy=%b expected pulse=00000 busy=0",
                     bus.err_pulse, bus.busy);
        end
        cyc(IN_WS);
        repeat (7) cyc(IN_NONE);
        bus.sout = 8'h41;
        cyc(IN_NONE);
        checks++;
        if (bus.err_pulse !== 5'b01000) begin
            failures++;
            $display("FAIL wout_bad: got %b expected %b", bus.err_pulse, 5'b01000);
        end
        bus.sout = 8'h20;
        cyc(IN_WS);
        repeat (4) cyc(IN_NONE);
        cyc(IN_CS);
        checks++;
        if (bus.err_pulse !== 5'b00100) begin
            failures++;
            $display("FAIL wgap_cs: got %b expected %b", bus.err_pulse, 5'b00100);
        end
        bus.sout = 8'h41;
        cyc(IN_NONE);
        cyc(IN_NONE);
        cyc(IN_NONE);
        checks++;
        if ({bus.err_pulse, bus.busy} !== {5'b00000, 1'b0}) begin
            failures++;
            $display("FAIL wout_cancel: got pulse=%b busy=%b expected pulse=00000 busy=0",
                     bus.err_pulse, bus.busy);
        end
        checks++;
        if ({bus.err_sticky, bus.err_cnt} !== {5'b01100, 8'd2}) begin
            failures++;
            $display("FAIL wout_sticky: got sticky=%b cnt=%0d expected sticky=01100 cnt=2",
                     bus.err_sticky, bus.err_cnt);
        end
        bus.sout = 8'hFF;
    endtask

    task automatic test_multi_in();
        do_reset(8'hFF);
        cyc(IN_NONE);
        cyc(IN_DOT | IN_DASH);
        checks++;
        if ({bus.err_pulse, bus.busy} !== {5'b00001, 1'b0}) begin
            failures++;
            $display("FAIL multi_dot_dash: got pulse=%b busy=%b expected pulse=00001 busy=0",
                     bus.err_pulse, bus.busy);
        end
        cyc(IN_CS | IN_WS);
        checks++;
        if ({bus.err_pulse, bus.busy} !== {5'b00001, 1'b0}) begin
            failures++;
            $display("FAIL multi_spaces: got pulse=%b busy=%b expected pulse=00001 busy=0",
                     bus.err_pulse, bus.busy);
        end
        cyc(IN_NONE);
        checks++;
        if (bus.err_pulse !== 5'b00000) begin
            failures++;
            $display("FAIL multi_one_cycle: got %b expected %b", bus.err_pulse, 5'b00000);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(8'hFF);
        cyc(IN_NONE);
        repeat (300) cyc(IN_DOT | IN_DASH);
        checks++;
        if ({bus.err_pulse, bus.err_cnt} !== {5'b00001, 8'd255}) begin
            failures++;
            $display("FAIL cnt_saturate: got pulse=%b cnt=%0d expected pulse=00001 cnt=255",
                     bus.err_pulse, bus.err_cnt);
        end
        bus.clr_err = 1'b1;
        cyc(IN_DOT | IN_DASH);
        bus.clr_err = 1'b0;
        checks++;
        if ({bus.err_sticky, bus.err_cnt} !== {5'b00001, 8'd1}) begin
            failures++;
            $display("FAIL clr_with_err: got sticky=%b cnt=%0d expected sticky=00001 cnt=1",
                     bus.err_sticky, bus.err_cnt);
        end
        bus.clr_err = 1'b1;
        cyc(IN_NONE);
        bus.clr_err = 1'b0;
        checks++;
        if ({bus.err_sticky, bus.err_cnt} !== {5'b00000, 8'd0}) begin
            failures++;
            $display("FAIL clr_plain: got sticky=%b cnt=%0d expected sticky=00000 cnt=0",
                     bus.err_sticky, bus.err_cnt);
        end
    endtask

    task automatic test_chk_en_and_rst();
        do_reset(8'hFF);
        cyc(IN_NONE);
        bus.chk_en = 1'b0;
        cyc(IN_CS);
        cyc(IN_NONE);
        cyc(IN_DASH);
        checks++;
        if ({bus.err_pulse, bus.err_sticky, bus.err_cnt} !== 18'd0) begin
            failures++;
            $display("FAIL chk_en_off: got pulse=%b sticky=%b cnt=%0d expected all 0",
                     bus.err_pulse, bus.err_sticky, bus.err_cnt);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL chk_en_fsm: got busy=%b expected %b", bus.busy, 1'b0);
        end
        do_reset(8'h00);
        cyc(IN_NONE);
        bus.chk_en = 1'b1;
        cyc(IN_NONE);
        checks++;
        if (bus.err_pulse !== 5'b00000) begin
            failures++;
            $display("FAIL idle_consumed: got %b expected %b", bus.err_pulse, 5'b00000);
        end
        do_reset(8'hFF);
        cyc(IN_NONE);
        cyc(IN_DOT | IN_DASH);
        cyc(IN_WS);
        cyc(IN_NONE);
        checks++;
        if ({bus.busy, bus.err_sticky} !== {1'b1, 5'b00001}) begin
            failures++;
            $display("FAIL wgap_before_rst: got busy=%b sticky=%b expected busy=1 sticky=00001",
                     bus.busy, bus.err_sticky);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.err_sticky, bus.err_cnt} !== 14'd0) begin
            failures++;
            $display("FAIL async_rst: got busy=%b sticky=%b cnt=%0d expected all 0",
                     bus.busy, bus.err_sticky, bus.err_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(IN_NONE);
        checks++;
        if ({bus.err_pulse, bus.busy} !== {5'b00000, 1'b0}) begin
            failures++;
            $display("FAIL after_rst: got pulse=%b busy=%b expected pulse=00000 busy=0",
                     bus.err_pulse, bus.busy);
        end
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        rst                = 1'b1;
        bus.chk_en         = 1'b1;
        bus.clr_err        = 1'b0;
        bus.dot_inp        = 1'b0;
        bus.dash_inp       = 1'b0;
        bus.char_space_inp = 1'b0;
        bus.word_space_inp = 1'b0;
        bus.sout           = 8'hFF;

        test_reset();
        test_char_gap();
        test_word_out();
        test_multi_in();
        test_back_to_back();
        test_chk_en_and_rst();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
